ne16_descale: RTL and testbench
===============================

// Module: ne16_descale
// PURPOSE
//  Streaming requantizer: the inverse of the left-shift scaler on the accumulator output path.
//  Takes wide signed accumulator words and applies a right shift with optional round-half-up.
//  Saturates each result to OUT_ACC bits, signed or unsigned, and feeds the streamer writeback.
//  Two-stage registered pipeline with full ready/valid handshake and a saturation event counter.
// PARAMETERS
//  INP_ACC   32  input accumulator width (two's complement)
//  OUT_ACC    8  output width; must be < INP_ACC
//  N_SHIFTS  32  number of selectable right shifts (0..N_SHIFTS-1); SHIFT_W = $clog2(N_SHIFTS)
// PORTS
//  clk_i        in   1        clock
//  rst_ni       in   1        async reset, active low
//  test_mode_i  in   1        test mode (no functional effect)
//  clear_i      in   1        sync flush of pipeline and counter
//  data_i       sink intf     hwpe stream, data[INP_ACC-1:0]
//  data_o       src  intf     hwpe stream, data[OUT_ACC-1:0]
//  shift_i      in   SHIFT_W  right-shift amount, sampled with each accepted beat
//  round_i      in   1        1: add 2^(shift-1) before shifting (ignored when shift=0)
//  signed_i     in   1        1: signed output range; 0: unsigned output range
//  sat_cnt_o    out  16       number of saturated beats since reset or clear; sticks at 0xFFFF
//  busy_o       out  1        any pipeline stage holds a valid beat
// BEHAVIOUR
//  Reset values: data_o.valid=0, data_o.data=0, sat_cnt_o=0, busy_o=0, both stage valids 0.
//  Stage 1 (S1)
//   - Captures data_i.data, shift_i, round_i, signed_i when data_i.valid & data_i.ready.
//  Stage 2 (S2)
//   - Registers the computed result and a per-beat sat flag.
//  Pipeline control
//   - data_o.valid = S2 valid.
//   - S2 loads when (!v2 | data_o.ready) & v1.
//   - data_i.ready = !v1 | S2 load (combinational, no dependence on data_i.valid).
//   - Bubbles collapse; throughput is 1 beat/cycle with data_o.ready held high.
//   - Latency is 2 cycles from input handshake to data_o.valid.
//  Stalls: data_o.data and data_o.valid stay stable while data_o.valid & !data_o.ready.
//  Ordering: beats are never dropped, duplicated or reordered.
//  data_o.strb is all-ones whenever data_o.valid is high.
//  Arithmetic (all in INP_ACC+1 bits, sign-extended, no intermediate wrap)
//   - t = x + (round & s>0 ? 1<<(s-1) : 0)
//   - y = t >>> s (arithmetic shift, floor)
//  Saturation
//   - signed_i=1: clip y to [-2^(OUT_ACC-1), 2^(OUT_ACC-1)-1].
//   - signed_i=0: clip y to [0, 2^OUT_ACC-1]; negative values clip to 0.
//   - sat flag = 1 when clipping changed the value.
//  sat_cnt_o
//   - Increments by 1 on each output handshake whose beat has sat=1.
//   - Saturates at 0xFFFF.
//  clear_i
//   - Next edge: v1=v2=0, sat_cnt_o=0, data_i.ready=1.
//   - An input handshake in the same cycle is discarded.
//   - clear_i has priority over every other update.
//  Async reset mid-stream: all state drops immediately to reset values; in-flight beats are lost.
//  busy_o = v1 | v2.
// TESTING
//  1. x=0x00000100, s=4, rnd=0, sgn=1 -> data_o=0x10, valid exactly 2 cycles after handshake.
//  2. Rounding:
//     - x=23, s=3, rnd=1 -> 0x03.
//     - x=-23, s=3, rnd=1 -> 0xFD.
//     - x=-23, s=3, rnd=0 -> 0xFD.
//     - x=20, s=3, rnd=1 -> 0x03.
//  3. Saturation, in sequence:
//     - 1000, s=0, sgn=1 -> 0x7F.
//     - -1000, s=0, sgn=1 -> 0x80.
//     - -5, s=0, sgn=0 -> 0x00.
//     - 300, s=0, sgn=0 -> 0xFF.
//     - sat_cnt_o=4 afterwards.
//  4. Round overflow: x=0x7FFFFFFF, s=1, rnd=1, sgn=1 -> 0x7F with sat=1 (no wrap).
//     x=0x80000000, s=31, sgn=1 -> 0xFF.
//  5. Backpressure: data_o.ready=0 for 6 cycles, data_i.valid=1 with beats 1..8.
//     - Only 2 accepted; data_o held at beat 1.
//     - After release, outputs 1..8 in order, 1/cycle.
//  6. clear_i with v1=v2=1 -> next cycle valid=0, sat_cnt_o=0.
//     rst_ni pulsed mid-burst -> outputs at reset values immediately.

Source files
------------

// File: rtl/ne16_descale.sv
// ne16_descale: two-stage streaming requantizer (right shift, optional round-half-up, clip to OUT_ACC)
module ne16_descale #(
  parameter int INP_ACC  = 32,
  parameter int OUT_ACC  = 8,
  parameter int N_SHIFTS = 32,
  parameter int SHIFT_W  = $clog2(N_SHIFTS),
  parameter int STRB_W   = (OUT_ACC + 7) / 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                clear_i,
  input  logic [INP_ACC-1:0]  data_i_data,
  input  logic                data_i_valid,
  output logic                data_i_ready,
  output logic [OUT_ACC-1:0]  data_o_data,
  output logic [STRB_W-1:0]   data_o_strb,
  output logic                data_o_valid,
  input  logic                data_o_ready,
  input  logic [SHIFT_W-1:0]  shift_i,
  input  logic                round_i,
  input  logic                signed_i,
  output logic [15:0]         sat_cnt_o,
  output logic                busy_o
);
  localparam int W = INP_ACC + 1;
  localparam logic signed [W-1:0] S_MAX = {{(W-OUT_ACC+1){1'b0}}, {(OUT_ACC-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN = {{(W-OUT_ACC+1){1'b1}}, {(OUT_ACC-1){1'b0}}};
  localparam logic signed [W-1:0] U_MAX = {{(W-OUT_ACC){1'b0}}, {OUT_ACC{1'b1}}};
  logic                unused_test_mode;
  logic                v1, v2, r1, g1, sat2, ld2, sat;
  logic [INP_ACC-1:0]  x1;
  logic [SHIFT_W-1:0]  s1;
  logic signed [W-1:0] rnd, t, y, hi, lo, c;
  assign unused_test_mode = test_mode_i;
  assign ld2 = (!v2 | data_o_ready) & v1;
  assign data_i_ready = !v1 | ld2;
  assign data_o_valid = v2;
  assign data_o_strb = '1;
  assign busy_o = v1 | v2;
  // one extra bit of headroom so the rounding add can never wrap
  always_comb begin
    rnd = (r1 && s1 != '0) ? W'(1) << (s1 - SHIFT_W'(1)) : '0;
    t   = $signed({x1[INP_ACC-1], x1}) + rnd;
    y   = t >>> s1;
    hi  = g1 ? S_MAX : U_MAX;
    lo  = g1 ? S_MIN : '0;
    c   = y > hi ? hi : y < lo ? lo : y;
    sat = c != y;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      x1 <= '0;
      s1 <= '0;
      r1 <= 1'b0;
      g1 <= 1'b0;
      data_o_data <= '0;
      sat2 <= 1'b0;
      sat_cnt_o <= '0;
    end else if (clear_i) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      sat_cnt_o <= '0;
    end else begin
      if (data_i_ready) v1 <= data_i_valid;
      if (data_i_ready & data_i_valid) begin
        x1 <= data_i_data;
        s1 <= shift_i;
        r1 <= round_i;
        g1 <= signed_i;
      end
      if (ld2) begin
        v2 <= 1'b1;
        data_o_data <= c[OUT_ACC-1:0];
        sat2 <= sat;
      end else if (data_o_ready) v2 <= 1'b0;
      if (v2 & data_o_ready & sat2 & ~&sat_cnt_o) sat_cnt_o <= sat_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_ne16_descale.sv
// tb_ne16_descale: scoreboard bench for the descale pipeline; a 64-bit reference model predicts each beat
module tb_ne16_descale;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        test_mode_i = 1'b0;
  logic        clear_i = 1'b0;
  logic [31:0] data_i_data = '0;
  logic        data_i_valid = 1'b0;
  logic        data_i_ready;
  logic [7:0]  data_o_data;
  logic [0:0]  data_o_strb;
  logic        data_o_valid;
  logic        data_o_ready = 1'b1;
  logic [4:0]  shift_i = '0;
  logic        round_i = 1'b0;
  logic        signed_i = 1'b1;
  logic [15:0] sat_cnt_o;
  logic        busy_o;
  int          n_run = 0, n_fail = 0, n_acc = 0, n_out = 0, sat_exp = 0;
  logic [8:0]  q[$];
  ne16_descale dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
    .data_i_data(data_i_data), .data_i_valid(data_i_valid), .data_i_ready(data_i_ready),
    .data_o_data(data_o_data), .data_o_strb(data_o_strb), .data_o_valid(data_o_valid),
    .data_o_ready(data_o_ready), .shift_i(shift_i), .round_i(round_i), .signed_i(signed_i),
    .sat_cnt_o(sat_cnt_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [31:0] x, input int s, input bit r, input bit g);
    longint t, y, hi, lo, c;
    t = longint'($signed(x));
    if (r && s > 0) t += longint'(1) << (s - 1);
    y = t >>> s;
    hi = g ? 127 : 255;
    lo = g ? -128 : 0;
    c = y > hi ? hi : y < lo ? lo : y;
    return {c != y, c[7:0]};
  endfunction
  // inputs only change just after posedge, so a handshake seen here completes at the next posedge
  always @(negedge clk_i) begin
    logic [8:0] e;
    if (!rst_ni || clear_i) begin
      q.delete();
      sat_exp = 0;
    end else begin
      if (data_o_valid && data_o_ready) begin
        chk("q_nonempty", q.size() != 0, 1);
        chk("sat_cnt", sat_cnt_o, sat_exp);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("data", data_o_data, e[7:0]);
          chk("strb", data_o_strb, 1);
          if (e[8] && sat_exp < 16'hFFFF) sat_exp++;
        end
        n_out++;
      end
      if (data_i_valid && data_i_ready) begin
        q.push_back(model(data_i_data, int'(shift_i), round_i, signed_i));
        n_acc++;
      end
    end
  end
  task automatic send(input logic [31:0] x, input int s, input bit r, input bit g);
    bit ok = 0;
    data_i_data = x;
    shift_i = s[4:0];
    round_i = r;
    signed_i = g;
    data_i_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (data_i_ready) begin
        ok = 1;
        break;
      end
    end
    chk("send_acc", ok, 1);
    @(posedge clk_i);
    #1 data_i_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk_i);
      #1;
      if (!busy_o) break;
    end
    chk("drain", busy_o, 0);
  endtask
  initial begin
    #12;
    chk("rst_valid", data_o_valid, 0);
    chk("rst_data", data_o_data, 0);
    chk("rst_sat", sat_cnt_o, 0);
    chk("rst_busy", busy_o, 0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send(32'h100, 4, 0, 1);
    chk("lat_early", data_o_valid, 0);
    @(posedge clk_i);
    #1 chk("lat_valid", data_o_valid, 1);
    drain();
    send(32'd23, 3, 1, 1);
    send(-32'sd23, 3, 1, 1);
    send(-32'sd23, 3, 0, 1);
    send(32'd20, 3, 1, 1);
    drain();
    send(32'd1000, 0, 0, 1);
    send(-32'sd1000, 0, 0, 1);
    send(-32'sd5, 0, 0, 0);
    send(32'd300, 0, 0, 0);
    drain();
    chk("sat_cnt_4", sat_cnt_o, 4);
    send(32'h7FFFFFFF, 1, 1, 1);
    send(32'h80000000, 31, 0, 1);
    drain();
    chk("sat_cnt_5", sat_cnt_o, 5);
    data_o_ready = 1'b0;
    n_acc = 0;
    fork
      for (int i = 1; i <= 8; i++) send(i, 0, 0, 1);
      begin
        int base;
        repeat (6) @(posedge clk_i);
        #1;
        chk("bp_acc", n_acc, 2);
        chk("bp_valid", data_o_valid, 1);
        chk("bp_hold", data_o_data, 1);
        base = n_out;
        data_o_ready = 1'b1;
        repeat (8) @(negedge clk_i);
        #1 chk("bp_rate", n_out - base, 8);
      end
    join
    drain();
    data_o_ready = 1'b0;
    data_i_data = 32'd7;
    shift_i = '0;
    data_i_valid = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("cl_busy_pre", busy_o, 1);
    chk("cl_ready_pre", data_i_ready, 0);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    data_i_valid = 1'b0;
    data_o_ready = 1'b1;
    chk("cl_valid", data_o_valid, 0);
    chk("cl_busy", busy_o, 0);
    chk("cl_sat", sat_cnt_o, 0);
    chk("cl_ready", data_i_ready, 1);
    fork
      for (int i = 0; i < 10; i++) send(32'd1000 + i, 0, 0, 1);
      begin
        repeat (5) @(posedge clk_i);
        #1 chk("rs_sat_pre", sat_cnt_o != 0, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rs_valid", data_o_valid, 0);
        chk("rs_data", data_o_data, 0);
        chk("rs_sat", sat_cnt_o, 0);
        chk("rs_busy", busy_o, 0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
      end
    join
    drain();
    chk("q_empty_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
